// File: rtl/fht_loader_if.sv
// Bundles the loader's sample handshake, its RAM(A) write port and its FHT core handshake.
// The loader connects through the slave modport; the surrounding logic connects through master.
interface fht_loader_if #(
  parameter int D_BIT    = 16,
  parameter int A_BIT    = 8,
  parameter int FCNT_BIT = 8
);
  logic                iVALID;
  logic [D_BIT-2:0]    iSAMPLE;
  logic                oREADY;
  logic [3:0]          oWE;
  logic [A_BIT-1:0]    oADDR_WR;
  logic [D_BIT-1:0]    oDATA;
  logic                oSTART;
  logic                iFHT_RDY;
  logic                iRELEASE;
  logic                oBUSY;
  logic [FCNT_BIT-1:0] oFRAME_CNT;

  modport slave (
    input  iVALID, iSAMPLE, iFHT_RDY, iRELEASE,
    output oREADY, oWE, oADDR_WR, oDATA, oSTART, oBUSY, oFRAME_CNT
  );

  modport master (
    output iVALID, iSAMPLE, iFHT_RDY, iRELEASE,
    input  oREADY, oWE, oADDR_WR, oDATA, oSTART, oBUSY, oFRAME_CNT
  );
endinterface

// File: rtl/fht_loader.sv
// Streams ADC samples into the four FHT RAM(A) banks, kicks the core, and holds the frame
// until the downstream reader releases it.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LOAD     | accepting samples, scattering them across the banks
// START    | last write strobe on the bus; start pulses next cycle
// WAIT_FHT | core running, waiting for its ready pulse
// HOLD     | result frame owned by the reader until release
module fht_loader #(
  parameter int D_BIT    = 16,
  parameter int A_BIT    = 8,
  parameter bit BIT_REV  = 1'b1,
  parameter int FCNT_BIT = 8
) (
  input logic        iCLK,
  input logic        iRESET,
  fht_loader_if.slave bus
);
  localparam int IDX_BIT = A_BIT + 2;

  typedef enum logic [1:0] {LOAD, START, WAIT_FHT, HOLD} state_t;

  state_t              state, state_nxt;
  logic [IDX_BIT-1:0]  idx;
  logic [IDX_BIT-1:0]  idx_rev;
  logic [IDX_BIT-1:0]  m;
  logic                xfer;
  logic                ready_q;
  logic                busy_q;
  logic                start_q;
  logic [3:0]          we_q;
  logic [A_BIT-1:0]    addr_q;
  logic [D_BIT-1:0]    data_q;
  logic [FCNT_BIT-1:0] frame_cnt;

  assign xfer = bus.iVALID && ready_q;

  always_comb begin
    idx_rev = '0;
    for (int i = 0; i < IDX_BIT; i++) idx_rev[i] = idx[IDX_BIT-1-i];
    m = BIT_REV ? idx_rev : idx;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:     if (xfer && (&idx)) state_nxt = START;
      START:    state_nxt = WAIT_FHT;
      WAIT_FHT: if (bus.iFHT_RDY) state_nxt = HOLD;
      HOLD:     if (bus.iRELEASE) state_nxt = LOAD;
      default:  state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) state <= LOAD;
    else         state <= state_nxt;
  end

  // Handshake/status flags follow the next state so they are registered, not decoded.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      idx       <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      we_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      frame_cnt <= '0;
    end else begin
      ready_q <= (state_nxt == LOAD);
      busy_q  <= (state_nxt != LOAD);
      start_q <= (state == START);
      we_q    <= '0;
      if (xfer) begin
        idx    <= idx + IDX_BIT'(1);
        we_q   <= 4'b0001 << m[1:0];
        addr_q <= m[IDX_BIT-1:2];
        data_q <= {bus.iSAMPLE[D_BIT-2], bus.iSAMPLE};
      end
      if (state == HOLD && bus.iRELEASE) frame_cnt <= frame_cnt + FCNT_BIT'(1);
    end
  end

  assign bus.oREADY     = ready_q;
  assign bus.oBUSY      = busy_q;
  assign bus.oSTART     = start_q;
  assign bus.oWE        = we_q;
  assign bus.oADDR_WR   = addr_q;
  assign bus.oDATA      = data_q;
  assign bus.oFRAME_CNT = frame_cnt;
endmodule

// File: tb/tb_fht_loader.sv
// Drives one random stimulus into a bit-reversed and a natural-order loader (N = 16, 2-bit
// frame counter) and compares both against a point-by-point reference model.
module tb_fht_loader;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [14:0] sample;
  logic        fht_rdy;
  logic        rel;

  int n_chk  = 0;
  int n_pass = 0;
  int frame_pos;
  int exp_cnt;

  always #5 clk = ~clk;

  fht_loader_if #(.D_BIT(16), .A_BIT(2), .FCNT_BIT(2)) bus_rev ();
  fht_loader_if #(.D_BIT(16), .A_BIT(2), .FCNT_BIT(2)) bus_nat ();

  assign bus_rev.iVALID   = valid;
  assign bus_rev.iSAMPLE  = sample;
  assign bus_rev.iFHT_RDY = fht_rdy;
  assign bus_rev.iRELEASE = rel;
  assign bus_nat.iVALID   = valid;
  assign bus_nat.iSAMPLE  = sample;
  assign bus_nat.iFHT_RDY = fht_rdy;
  assign bus_nat.iRELEASE = rel;

  fht_loader #(.D_BIT(16), .A_BIT(2), .BIT_REV(1'b1), .FCNT_BIT(2)) u_rev (
    .iCLK(clk), .iRESET(rst_n), .bus(bus_rev));
  fht_loader #(.D_BIT(16), .A_BIT(2), .BIT_REV(1'b0), .FCNT_BIT(2)) u_nat (
    .iCLK(clk), .iRESET(rst_n), .bus(bus_nat));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int rev_idx(input int v, input int bits);
    int r = 0;
    int x = v;
    for (int i = 0; i < bits; i++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  function automatic int sext(input int s);
    return (s >= 16384) ? s + 32768 : s;
  endfunction

  task automatic check_point(input int idx, input int smp);
    int mr = rev_idx(idx, 4);
    chk("we_rev",   bus_rev.oWE,      32'(1 << (mr % 4)));
    chk("addr_rev", bus_rev.oADDR_WR, 32'(mr / 4));
    chk("data_rev", bus_rev.oDATA,    32'(sext(smp)));
    chk("we_nat",   bus_nat.oWE,      32'(1 << (idx % 4)));
    chk("addr_nat", bus_nat.oADDR_WR, 32'(idx / 4));
    chk("data_nat", bus_nat.oDATA,    32'(sext(smp)));
  endtask

  // mode 0: valid always high, 1: toggling 1,0,1,0, 2: random gaps
  task automatic load_points(input int count, input int mode);
    int n = 0, cyc = 0, seen = 0, pend_idx = 0, pend_smp = 0, smp;
    bit pend = 1'b0, v;
    while ((n < count || pend) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus_rev.oWE != 4'b0) seen++;
      if (pend) check_point(pend_idx, pend_smp);
      else begin
        chk("we_idle_rev", bus_rev.oWE, 0);
        chk("we_idle_nat", bus_nat.oWE, 0);
      end
      chk("ready", bus_rev.oREADY, 32'(frame_pos < N));
      chk("busy",  bus_nat.oBUSY,  32'(frame_pos >= N));
      if (n < count) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = (cyc % 2 == 1);
          default: v = 1'($urandom_range(0, 1));
        endcase
        if (frame_pos == 0)      smp = 'h4000;
        else if (frame_pos == 1) smp = 'h3FFF;
        else                     smp = int'($urandom_range(0, 32767));
        valid  = v;
        sample = 15'(smp);
        pend   = v;
        if (v) begin
          pend_idx = frame_pos;
          pend_smp = smp;
          frame_pos++;
          n++;
        end
      end else begin
        valid = 1'b0;
        pend  = 1'b0;
      end
    end
    if (cyc >= 400) chk("load_timeout", 32'(n), 32'(count));
    chk("strobe_count", 32'(seen), 32'(count));
  endtask

  task automatic finish_frame();
    valid  = 1'b1;
    sample = 15'h1234;
    @(negedge clk);
    chk("start_rev", bus_rev.oSTART, 1);
    chk("start_nat", bus_nat.oSTART, 1);
    chk("we_after_last", bus_rev.oWE, 0);
    chk("ready_start", bus_rev.oREADY, 0);
    @(negedge clk);
    chk("start_once", bus_rev.oSTART, 0);
    chk("we_no_extra", bus_nat.oWE, 0);
    rel = 1'b1;
    @(negedge clk);
    rel = 1'b0;
    chk("release_ignored_ready", bus_rev.oREADY, 0);
    chk("release_ignored_busy",  bus_rev.oBUSY, 1);
    chk("release_ignored_cnt",   bus_rev.oFRAME_CNT, 32'(exp_cnt));
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      chk("start_quiet", bus_rev.oSTART, 0);
    end
    fht_rdy = 1'b1;
    @(negedge clk);
    fht_rdy = 1'b0;
    valid   = 1'b0;
    chk("hold_busy",  bus_rev.oBUSY, 1);
    chk("hold_ready", bus_nat.oREADY, 0);
    chk("hold_we",    bus_rev.oWE, 0);
    @(negedge clk);
    chk("hold_cnt", bus_rev.oFRAME_CNT, 32'(exp_cnt));
    rel = 1'b1;
    @(negedge clk);
    rel       = 1'b0;
    exp_cnt   = (exp_cnt + 1) % 4;
    frame_pos = 0;
    chk("released_ready", bus_rev.oREADY, 1);
    chk("released_busy",  bus_nat.oBUSY, 0);
    chk("frame_cnt_rev",  bus_rev.oFRAME_CNT, 32'(exp_cnt));
    chk("frame_cnt_nat",  bus_nat.oFRAME_CNT, 32'(exp_cnt));
  endtask

  initial begin
    rst_n     = 1'b0;
    valid     = 1'b0;
    sample    = '0;
    fht_rdy   = 1'b0;
    rel       = 1'b0;
    frame_pos = 0;
    exp_cnt   = 0;
    repeat (3) @(negedge clk);
    chk("rst_we",    bus_rev.oWE, 0);
    chk("rst_addr",  bus_rev.oADDR_WR, 0);
    chk("rst_data",  bus_rev.oDATA, 0);
    chk("rst_start", bus_rev.oSTART, 0);
    chk("rst_cnt",   bus_rev.oFRAME_CNT, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus_rev.oREADY, 1);
    chk("rst_busy",  bus_rev.oBUSY, 0);

    load_points(N, 0);
    finish_frame();
    load_points(N, 1);
    finish_frame();

    // abandon a frame after 7 points; reset must clear strobes immediately
    load_points(7, 2);
    chk("pre_reset_we", 32'(bus_rev.oWE != 4'b0), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_we_rev", bus_rev.oWE, 0);
    chk("async_rst_we_nat", bus_nat.oWE, 0);
    chk("async_rst_cnt",    bus_rev.oFRAME_CNT, 0);
    frame_pos = 0;
    exp_cnt   = 0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int f = 0; f < 4; f++) begin
      load_points(N, f % 3);
      finish_frame();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fht_loader.md
Name: fht_loader

Overview:
- Upstream feeder for the FHT core.
- Accepts a serial stream of ADC samples over a valid/ready handshake and sign-extends each one.
- Scatters a full frame of N = 4*BANK_SIZE points across the four RAM(A) banks, in natural or bit-reversed order, using the core's bank-select write strobes and per-bank write address.
- After the last write lands, issues the start strobe, waits for the core's ready pulse, then holds the frame until the downstream reader releases it.

Parameters:
- D_BIT, 16: data width at the core (signed, after extension).
- A_BIT, 8: bank address width; BANK_SIZE = 2^A_BIT, so N = 2^(A_BIT+2).
- BIT_REV, 1: 1 = write point n at bit-reversed index rev(n) over A_BIT+2 bits; 0 = natural order.
- FCNT_BIT, 8: width of the frame counter.

Ports:
- iCLK  in  1  system clock, rising edge.
- iRESET  in  1  asynchronous, active-low reset.
- iVALID  in  1  sample valid from ADC interface.
- iSAMPLE  in  D_BIT-1  signed ADC sample, not yet extended.
- oREADY  out  1  loader can accept a sample this cycle.
- oWE  out  4  one-hot bank write strobe to the core's bank-choice write enable.
- oADDR_WR  out  A_BIT  per-bank write address to the core.
- oDATA  out  D_BIT  sign-extended sample to the core.
- oSTART  out  1  one-cycle start strobe to the core.
- iFHT_RDY  in  1  one-cycle completion pulse from the core.
- iRELEASE  in  1  downstream reader done with the result frame.
- oBUSY  out  1  high in any state other than LOAD.
- oFRAME_CNT  out  FCNT_BIT  completed (released) frames, wraps modulo 2^FCNT_BIT.

Behaviour:
- Reset (iRESET low, asynchronous):
  - state = LOAD, point index = 0.
  - oWE = 0, oADDR_WR = 0, oDATA = 0, oSTART = 0, oFRAME_CNT = 0.
  - oREADY = 1, oBUSY = 0 once reset deasserts.
  - A reset mid-frame discards the partial frame; the next accepted sample is index 0.
- State LOAD:
  - oREADY = 1.
  - Transfer occurs when iVALID && oREADY.
  - On a transfer of point n: m = BIT_REV ? rev(n) : n. Next cycle (registered, latency 1): oWE = 1 << m[1:0], oADDR_WR = m[A_BIT+1:2], oDATA = {iSAMPLE[D_BIT-2], iSAMPLE}.
  - Index increments by 1 per transfer.
  - oWE is 0 in any cycle with no transfer in the previous cycle. oADDR_WR and oDATA hold their last value.
  - On the transfer of n = N-1: index wraps to 0, state -> START, and oREADY drops in the following cycle (no sample N is accepted).
- State START:
  - Entered the cycle the last write strobe is presented.
  - oSTART = 1 for exactly one cycle, the cycle after the last oWE, so the last point is already written when the core samples start.
  - Then -> WAIT_FHT.
- State WAIT_FHT:
  - oREADY = 0.
  - On iFHT_RDY = 1 -> HOLD.
  - iRELEASE is ignored in this state.
- State HOLD:
  - oREADY = 0; the result frame is protected from overwrite.
  - On iRELEASE = 1 -> LOAD and oFRAME_CNT += 1 (wraps).
  - iFHT_RDY is ignored in this state.
- Cross-state rules:
  - iFHT_RDY and iRELEASE are ignored in LOAD and START.
  - oBUSY = (state != LOAD).
  - With iVALID held high in LOAD, one sample is accepted per cycle (full throughput). Gaps in iVALID only delay the frame; index and order are unaffected.
  - All outputs are registered; no combinational path from iVALID to oWE.

Test Plan:
- A_BIT=2 (N=16), BIT_REV=1; stream samples 0..15 with iVALID always high:
  - n=1 -> oWE=0001, oADDR_WR=2.
  - n=5 -> oWE=0100, oADDR_WR=2.
  - n=3 -> oWE=0001, oADDR_WR=3.
  - Exactly 16 strobes; oSTART high for one cycle, one cycle after the 16th strobe; oREADY low from the cycle after the 16th transfer.
- Same configuration with BIT_REV=0: n=6 -> oWE=0100, oADDR_WR=1; n=15 -> oWE=1000, oADDR_WR=3.
- Sign extension, D_BIT=16: iSAMPLE=15'h4000 -> oDATA=16'hC000; iSAMPLE=15'h3FFF -> oDATA=16'h3FFF.
- Handshake and release:
  - iVALID toggling 1,0,1,0 -> strobes only after valid cycles; the frame still completes after 16 transfers.
  - iRELEASE pulsed in WAIT_FHT is ignored.
  - iFHT_RDY pulse -> HOLD; iRELEASE -> LOAD, oFRAME_CNT 0 -> 1, oREADY = 1 the next cycle.
- Reset mid-frame: assert iRESET low after 7 transfers -> oWE = 0 immediately (asynchronous). After release, the next sample writes index 0 (oWE=0001, oADDR_WR=0) and the frame needs 16 more transfers.
- Frame counter wrap: FCNT_BIT=2, run 4 full frames -> oFRAME_CNT 1,2,3,0.
